icache_sa: RTL
==============

# icache_sa

Parametrised set-associative instruction cache sitting between the instruction queue's fetch stage and the memory controller. Lookup is combinational, the same cycle as the request. Misses are refilled a whole line at a time by an internal state machine over a word-granular request/acknowledge memory port. A flush input invalidates every line, for fence.i or a self-modifying-code reset.

## Interface
- WAYS, 2, associativity; power of two, 1..8
- SETS, 64, sets per way; power of two, ≥2
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when 0, all state is frozen and mem_ack is ignored
- fetch_valid  in  1  fetch request present
- fetch_addr  in  32  byte address of the instruction; bits [1:0] are ignored
- fetch_hit  out  1  combinational; 1 when fetch_valid and the line is resident
- fetch_inst  out  32  combinational; instruction when fetch_hit, else 0
- flush  in  1  invalidate all lines
- mem_req  out  1  registered; a word read is outstanding
- mem_addr  out  32  registered; word-aligned address of the outstanding read
- mem_ack  in  1  one-cycle pulse; mem_data is valid this cycle
- mem_data  in  32  returned word
- busy  out  1  registered; 1 in REFILL or DRAIN

## Operation
- Address split: offset = log2(LINE_WORDS) bits above [1:0]; index = next log2(SETS) bits; tag = remaining upper bits.
- Lookup: compare the tag against all WAYS valid entries of the indexed set.
  - At most one way matches.
  - fetch_inst is the selected word of the matching way.
- Lookups stay live in every state (hit-under-miss).
- States: IDLE, REFILL, DRAIN.
- IDLE: fetch_valid & ~fetch_hit & ~flush →
  - latch the line base address;
  - word counter = 0;
  - mem_req=1, mem_addr=base;
  - go to REFILL.
- REFILL: on mem_ack, store mem_data into line buffer[counter].
  - If the counter is not at its last value: increment it, mem_addr += 4, mem_req stays 1.
  - On the last word: write the buffer, tag and valid=1 into the victim way; advance that set's victim pointer; mem_req=0; go to IDLE.
- Victim selection: first invalid way of the set; if all ways are valid, the per-set round-robin pointer (log2(WAYS) bits, wraps).
- Partial lines are never visible; the array is written only when the line completes.
- Misses to other addresses while busy are ignored. The instruction queue retries them.
- flush in IDLE: all valid bits clear next cycle; victim pointers reset to 0.
- flush in REFILL: all valid bits clear.
  - If mem_ack is present in the same cycle: mem_req drops and the state goes to IDLE.
  - Otherwise: go to DRAIN, keeping mem_req=1.
  - The line is discarded.
- DRAIN: wait for mem_ack, discard the data, mem_req=0, go to IDLE.
- flush and a miss in the same cycle: flush wins and no refill starts.
- rst at any time, including mid-refill:
  - all valid bits, pointers and counter clear;
  - state = IDLE;
  - mem_req=0, mem_addr=0, busy=0.
  - fetch_hit is therefore 0 after reset.

## Timing
- Hit latency: 0 cycles (combinational).
- Miss detected in cycle 0 → mem_req=1 and mem_addr=line base in cycle 1.
- The memory may ack at the earliest the cycle after each mem_addr change. mem_addr is held stable until ack.
- The last ack in cycle t → in cycle t+1 the line is valid, busy=0, and fetch_hit=1 for the missed address.
- Minimum miss penalty: 2·LINE_WORDS+1 cycles.
- When rdy=0, mem_req and mem_addr hold and no transition occurs.

## Structure
- Package icache_pkg holds:
  - the state enum (IDLE, REFILL, DRAIN);
  - the derived width helpers: OFF_W, IDX_W, TAG_W = 32-2-OFF_W-IDX_W.
- Sub-module icache_way is instantiated WAYS times. Each instance holds:
  - valid/tag/data storage for SETS lines;
  - one read port: combinational tag compare, hit and word output;
  - one line-write port;
  - a clear-all input.
- The top level holds the FSM, line buffer, victim pointers and hit mux.

## Test plan
- Reset, then fetch 0x0000_1000 → fetch_hit=0; cycle 1 mem_req=1, mem_addr=0x1000. Ack words 0x13,0x93,0x113,0x193 → then fetch 0x100C returns 0x193 with hit=1.
- WAYS=2, SETS=64, LINE_WORDS=4: fill 0x1000 and 0x2000 (same set), then miss on 0x3000 → it replaces the way holding 0x1000 (pointer 0). Both 0x2000 and 0x3000 then hit; 0x1000 misses.
- Hit-under-miss: while refilling 0x4000, fetch the resident 0x1000 → hit=1, correct data. A fetch of 0x5000 issues no second request.
- Flush after the second of 4 acks with no ack that cycle → DRAIN; the next ack is discarded, mem_req=0, busy=0. 0x4000 and all prior lines miss.
- rdy=0 for 3 cycles mid-refill with mem_ack pulsing → mem_addr is unchanged and the counter does not advance. Refill resumes when rdy=1.
- rst asserted mid-refill → next cycle mem_req=0, busy=0; every prior address misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
// Latency: none; constants and elaboration-time functions only.
// Backpressure: not applicable.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   // Word-offset bits within a line (OFF_W).
   function automatic int off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   // Set-index bits (IDX_W).
   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   // Tag bits (TAG_W): whatever remains of the word address.
   function automatic int tag_w(input int line_words, input int sets);
      return 32 - 2 - off_w(line_words) - idx_w(sets);
   endfunction

   // Storage width for a field that may be zero bits wide.
   function automatic int at_least_one(input int w);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the cache: valid/tag/data for every set, combinational read, line write, bulk clear.
// Latency: read is combinational; a line write is visible the cycle after wr_en.
// Backpressure: none; the owner gates wr_en and clear_all.
module icache_way
   import icache_pkg::*;
#(
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = 6,
   parameter int TAG_W      = 22,
   parameter int OFS_W      = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear_all,
   input  logic [IDX_W-1:0]           rd_idx,
   input  logic [TAG_W-1:0]           rd_tag,
   input  logic [OFS_W-1:0]           rd_off,
   output logic                       rd_hit,
   output logic [31:0]                rd_word,
   input  logic                       wr_en,
   input  logic [IDX_W-1:0]           wr_idx,
   input  logic [TAG_W-1:0]           wr_tag,
   input  logic [LINE_WORDS*32-1:0]   wr_line,
   output logic                       wr_set_valid
);

   logic [SETS-1:0]          valid;
   logic [TAG_W-1:0]         tags  [SETS];
   logic [LINE_WORDS*32-1:0] lines [SETS];

   assign rd_hit       = valid[rd_idx] && (tags[rd_idx] == rd_tag);
   assign rd_word      = lines[rd_idx][rd_off*32 +: 32];
   assign wr_set_valid = valid[wr_idx];

   // Valid bits: cleared by reset or flush, set when a completed line lands.
   always_ff @(posedge clk) begin
      if (rst || clear_all)
         valid <= '0;
      else if (wr_en)
         valid[wr_idx] <= 1'b1;
   end

   // Tag and data payload; meaningless until the matching valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_idx]  <= wr_tag;
         lines[wr_idx] <= wr_line;
      end
   end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache with whole-line refill over a word request/ack memory port.
// Latency: hits are combinational; a miss costs at least 2*LINE_WORDS+1 cycles.
// Backpressure: rdy=0 freezes all state; misses while busy are dropped for the fetcher to retry.
module icache_sa
   import icache_pkg::*;
#(
   parameter int WAYS       = 2,
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_addr,
   output logic        fetch_hit,
   output logic [31:0] fetch_inst,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_data,
   output logic        busy
);

   localparam int OFF_W = off_w(LINE_WORDS);
   localparam int IDX_W = idx_w(SETS);
   localparam int TAG_W = tag_w(LINE_WORDS, SETS);
   localparam int OFS_W = at_least_one(OFF_W);
   localparam int PTR_W = at_least_one($clog2(WAYS));

   localparam logic [OFS_W-1:0] OFF_MASK  = OFS_W'(LINE_WORDS - 1);
   localparam logic [OFS_W-1:0] LAST      = OFS_W'(LINE_WORDS - 1);
   localparam logic [PTR_W-1:0] PTR_MASK  = PTR_W'(WAYS - 1);
   localparam logic [31:0]      LINE_MASK = 32'(LINE_WORDS * 4 - 1);

   // Address split of the incoming fetch; byte-select bits play no part.
   logic [29:0]      word_addr;
   logic [OFS_W-1:0] fetch_off;
   logic [IDX_W-1:0] fetch_idx;
   logic [TAG_W-1:0] fetch_tag;
   logic             unused_byte_sel;

   assign word_addr       = fetch_addr[31:2];
   assign fetch_off       = word_addr[OFS_W-1:0] & OFF_MASK;
   assign fetch_idx       = word_addr[OFF_W +: IDX_W];
   assign fetch_tag       = word_addr[OFF_W+IDX_W +: TAG_W];
   assign unused_byte_sel = ^fetch_addr[1:0];

   state_t             state;
   logic [OFS_W-1:0]   cnt;
   logic [IDX_W-1:0]   line_idx;
   logic [TAG_W-1:0]   line_tag;
   logic [31:0]        line_buf [LINE_WORDS];
   logic [PTR_W-1:0]   vptr     [SETS];

   logic [WAYS-1:0]          way_hit;
   logic [31:0]              way_word [WAYS];
   logic [WAYS-1:0]          set_valid;
   logic [PTR_W-1:0]         victim;
   logic                     victim_found;
   logic                     line_done;
   logic                     clear_all;
   logic [LINE_WORDS*32-1:0] wr_line;

   // The array only changes on the final beat of an unflushed refill, or on flush.
   assign line_done = rdy && (state == REFILL) && mem_ack && !flush && (cnt == LAST);
   assign clear_all = rdy && flush;

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      icache_way #(
         .SETS       (SETS),
         .LINE_WORDS (LINE_WORDS),
         .IDX_W      (IDX_W),
         .TAG_W      (TAG_W),
         .OFS_W      (OFS_W)
      ) u_way (
         .clk          (clk),
         .rst          (rst),
         .clear_all    (clear_all),
         .rd_idx       (fetch_idx),
         .rd_tag       (fetch_tag),
         .rd_off       (fetch_off),
         .rd_hit       (way_hit[g]),
         .rd_word      (way_word[g]),
         .wr_en        (line_done && (victim == PTR_W'(g))),
         .wr_idx       (line_idx),
         .wr_tag       (line_tag),
         .wr_line      (wr_line),
         .wr_set_valid (set_valid[g])
      );
   end

   assign fetch_hit = fetch_valid && (|way_hit);

   // Hit mux: at most one way matches, so OR-ing the gated words selects it.
   always_comb begin
      fetch_inst = '0;
      if (fetch_valid) begin
         for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w])
               fetch_inst = fetch_inst | way_word[w];
         end
      end
   end

   // Victim: lowest invalid way of the refilling set, else its round-robin pointer.
   always_comb begin
      victim       = vptr[line_idx];
      victim_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!victim_found && !set_valid[w]) begin
            victim       = PTR_W'(w);
            victim_found = 1'b1;
         end
      end
   end

   // Completed line image: buffered words plus the word arriving on the last beat.
   always_comb begin
      wr_line = '0;
      for (int w = 0; w < LINE_WORDS; w++)
         wr_line[w*32 +: 32] = (OFS_W'(w) == cnt) ? mem_data : line_buf[w];
   end

   // Line buffer collects refill words; stale contents never escape a discarded line.
   always_ff @(posedge clk) begin
      if (rdy && (state == REFILL) && mem_ack && !flush)
         line_buf[cnt] <= mem_data;
   end

   // Refill controller with registered memory-port outputs and victim pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         busy     <= 1'b0;
         line_idx <= '0;
         line_tag <= '0;
         for (int s = 0; s < SETS; s++)
            vptr[s] <= '0;
      end else if (rdy) begin
         case (state)
            IDLE: begin
               if (flush) begin
                  for (int s = 0; s < SETS; s++)
                     vptr[s] <= '0;
               end else if (fetch_valid && !fetch_hit) begin
                  line_idx <= fetch_idx;
                  line_tag <= fetch_tag;
                  cnt      <= '0;
                  mem_req  <= 1'b1;
                  mem_addr <= fetch_addr & ~LINE_MASK;
                  busy     <= 1'b1;
                  state    <= REFILL;
               end
            end
            REFILL: begin
               if (flush) begin
                  // The in-flight word must still be consumed unless it arrives now.
                  if (mem_ack) begin
                     mem_req <= 1'b0;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     state   <= DRAIN;
                  end
               end else if (mem_ack) begin
                  if (cnt == LAST) begin
                     mem_req        <= 1'b0;
                     busy           <= 1'b0;
                     state          <= IDLE;
                     vptr[line_idx] <= (vptr[line_idx] + 1'b1) & PTR_MASK;
                  end else begin
                     cnt      <= cnt + 1'b1;
                     mem_addr <= mem_addr + 32'd4;
                  end
               end
            end
            DRAIN: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
